pwm_speed_decoder: RTL and testbench



---
 rtl/pwm_pkg.sv | 42 ++++
 rtl/sync_edge.sv | 28 ++
 rtl/pwm_speed_decoder.sv | 136 +++++++++++++
 tb/tb_pwm_speed_decoder.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared types, constants and arithmetic helpers for the PWM speed decoder.
`timescale 1ns/1ps
package pwm_pkg;

  localparam int PWM_PERIOD = 4096;

  typedef logic signed [11:0] spd_t;

  localparam spd_t SPD_MAX = 12'sh7FF;
  localparam spd_t SPD_MIN = 12'sh800;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    MEAS = 1'b1
  } pwm_dec_state_e;

  // Half the high-time difference, clamped to the 12-bit signed range.
  function automatic spd_t counts_to_spd(input logic [13:0] hi1, input logic [13:0] hi2);
    logic signed [14:0] d;
    logic signed [14:0] s;
    d = $signed({1'b0, hi1}) - $signed({1'b0, hi2});
    s = d >>> 1;
    if (s > 15'sd2047) begin
      return SPD_MAX;
    end else if (s < -15'sd2048) begin
      return SPD_MIN;
    end else begin
      return s[11:0];
    end
  endfunction

  function automatic spd_t stall_spd(input logic lvl1, input logic lvl2);
    if (lvl1) begin
      return SPD_MAX;
    end else if (lvl2) begin
      return SPD_MIN;
    end else begin
      return 12'sh000;
    end
  endfunction

endpackage

// File: rtl/sync_edge.sv
// Multi-flop input synchronizer with a registered level and rising-edge strobe.
`timescale 1ns/1ps
module sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic lvl,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync;

  // lvl and rise are registered together so rise is always accompanied by lvl=1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync <= '0;
      lvl  <= 1'b0;
      rise <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], din};
      lvl  <= sync[SYNC_STAGES-1];
      rise <= sync[SYNC_STAGES-1] & ~lvl;
    end
  end

endmodule

// File: rtl/pwm_speed_decoder.sv
// Recovers the signed speed command from a complementary PWM pair, one result per period,
// and flags a stall when PWM1 stops producing rising edges.
`timescale 1ns/1ps
module pwm_speed_decoder
  import pwm_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 8192
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        PWM1,
  input  logic        PWM2,
  output logic [11:0] spd,
  output logic        vld,
  output logic        stalled
);

  localparam logic [13:0] PER_LAST = 14'(TIMEOUT - 1);

  logic lvl1;
  logic lvl2;
  logic rise1;
  logic rise2_unused;

  pwm_dec_state_e state;
  pwm_dec_state_e state_nxt;
  logic [13:0]    per;
  logic [13:0]    per_nxt;
  logic [13:0]    hi1;
  logic [13:0]    hi1_nxt;
  logic [13:0]    hi2;
  logic [13:0]    hi2_nxt;
  spd_t           spd_nxt;
  logic           vld_nxt;
  logic           stalled_nxt;

  sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync1 (
    .clk  (clk),
    .rst  (rst),
    .din  (PWM1),
    .lvl  (lvl1),
    .rise (rise1)
  );

  sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync2 (
    .clk  (clk),
    .rst  (rst),
    .din  (PWM2),
    .lvl  (lvl2),
    .rise (rise2_unused)
  );

  // State, counters and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      per     <= 14'd0;
      hi1     <= 14'd0;
      hi2     <= 14'd0;
      spd     <= 12'd0;
      vld     <= 1'b0;
      stalled <= 1'b0;
    end else begin
      state   <= state_nxt;
      per     <= per_nxt;
      hi1     <= hi1_nxt;
      hi2     <= hi2_nxt;
      spd     <= spd_nxt;
      vld     <= vld_nxt;
      stalled <= stalled_nxt;
    end
  end

  // A rise1 cycle opens a new window and is counted in it; rise1 beats a same-cycle timeout.
  always_comb begin
    state_nxt   = state;
    per_nxt     = per;
    hi1_nxt     = hi1;
    hi2_nxt     = hi2;
    spd_nxt     = spd_t'(spd);
    vld_nxt     = 1'b0;
    stalled_nxt = stalled;
    case (state)
      IDLE: begin
        hi1_nxt = 14'd0;
        hi2_nxt = 14'd0;
        if (rise1) begin
          state_nxt   = MEAS;
          per_nxt     = 14'd1;
          hi1_nxt     = {13'd0, lvl1};
          hi2_nxt     = {13'd0, lvl2};
          stalled_nxt = 1'b0;
        end else if (per == PER_LAST) begin
          per_nxt = PER_LAST;
          if (!stalled) begin
            vld_nxt     = 1'b1;
            stalled_nxt = 1'b1;
            spd_nxt     = stall_spd(lvl1, lvl2);
          end else begin
            stalled_nxt = 1'b1;
          end
        end else begin
          per_nxt = per + 14'd1;
        end
      end
      MEAS: begin
        if (rise1) begin
          spd_nxt = counts_to_spd(hi1, hi2);
          vld_nxt = 1'b1;
          per_nxt = 14'd1;
          hi1_nxt = {13'd0, lvl1};
          hi2_nxt = {13'd0, lvl2};
        end else if (per == PER_LAST) begin
          state_nxt   = IDLE;
          vld_nxt     = 1'b1;
          stalled_nxt = 1'b1;
          spd_nxt     = stall_spd(lvl1, lvl2);
          hi1_nxt     = 14'd0;
          hi2_nxt     = 14'd0;
        end else begin
          per_nxt = per + 14'd1;
          hi1_nxt = hi1 + {13'd0, lvl1};
          hi2_nxt = hi2 + {13'd0, lvl2};
        end
      end
      default: begin
        state_nxt = IDLE;
        per_nxt   = 14'd0;
        hi1_nxt   = 14'd0;
        hi2_nxt   = 14'd0;
      end
    endcase
  end

endmodule

// File: tb/tb_pwm_speed_decoder.sv
// Directed bench: drives PWM periods with known high times and checks each reported speed.
`timescale 1ns/1ps
module tb_pwm_speed_decoder;
  import pwm_pkg::*;

  localparam int TIMEOUT = 8192;
  localparam int DB      = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pwm1 = 1'b0;
  logic        pwm2 = 1'b0;
  logic [11:0] spd;
  logic        vld;
  logic        stalled;

  int          errors = 0;
  int          checks = 0;
  int          vld_cnt = 0;
  int          n = 0;
  logic [11:0] last_spd = 12'd0;

  always #5 clk = ~clk;

  pwm_speed_decoder #(.SYNC_STAGES(2), .TIMEOUT(TIMEOUT)) dut (
    .clk     (clk),
    .rst     (rst),
    .PWM1    (pwm1),
    .PWM2    (pwm2),
    .spd     (spd),
    .vld     (vld),
    .stalled (stalled)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (vld === 1'b1) begin
      vld_cnt++;
      last_spd = spd;
    end
  endtask

  task automatic hold(input int cycles);
    repeat (cycles) step();
  endtask

  task automatic period(input int h1, input int g1, input int h2, input int g2);
    vld_cnt = 0;
    pwm1 = 1'b1; pwm2 = 1'b0; hold(h1);
    pwm1 = 1'b0;              hold(g1);
    pwm2 = 1'b1;              hold(h2);
    pwm2 = 1'b0;              hold(g2);
  endtask

  task automatic duty(input int dty);
    period(dty - DB, DB, PWM_PERIOD - dty - DB, DB);
  endtask

  task automatic wait_vld(input int limit, output int cycles);
    cycles  = 0;
    vld_cnt = 0;
    while (vld_cnt == 0 && cycles < limit) begin
      step();
      cycles++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    hold(3);
    check("reset_spd", spd, 12'h000);
    check("reset_vld", vld, 1'b0);
    check("reset_stalled", stalled, 1'b0);

    // Both inputs idle from reset: one stall strobe, then silence.
    rst = 1'b0;
    wait_vld(TIMEOUT + 50, n);
    check("idle_stall_latency", n, TIMEOUT);
    check("idle_stall_spd", last_spd, 12'h000);
    check("idle_stall_flag", stalled, 1'b1);
    vld_cnt = 0;
    hold(300);
    check("idle_no_restrobe", vld_cnt, 0);

    duty(12'h800);
    check("first_window_silent", vld_cnt, 0);
    check("stall_cleared", stalled, 1'b0);
    duty(12'h800);
    check("d800_count", vld_cnt, 1);
    check("d800_spd", last_spd, 12'h000);
    duty(12'hC00);
    check("d800b_spd", last_spd, 12'h000);
    duty(12'hC00);
    check("dC00_count", vld_cnt, 1);
    check("dC00_spd", last_spd, 12'h400);
    duty(12'h400);
    check("dC00b_spd", last_spd, 12'h400);
    period(4095, 1, 0, 0);
    check("d400_spd", last_spd, 12'hC00);
    period(1, 0, 4094, 1);
    check("max_exact_spd", last_spd, 12'h7FF);
    period(5000, 4, 0, 4);
    check("neg_exact_spd", last_spd, 12'h801);
    period(1, 4, 5000, 4);
    check("sat_pos_spd", last_spd, 12'h7FF);
    duty(12'hC00);
    check("sat_neg_spd", last_spd, 12'h800);
    check("sat_neg_count", vld_cnt, 1);
    check("run_stalled", stalled, 1'b0);

    // PWM1 stuck high after a final rise.
    pwm1 = 1'b1; pwm2 = 1'b0;
    wait_vld(20, n);
    check("report_latency", n, 4);
    check("hold_rise_spd", last_spd, 12'h400);
    wait_vld(TIMEOUT + 50, n);
    check("hi_stall_latency", n, TIMEOUT - 1);
    check("hi_stall_spd", last_spd, 12'h7FF);
    check("hi_stall_flag", stalled, 1'b1);
    vld_cnt = 0;
    hold(200);
    check("hi_no_restrobe", vld_cnt, 0);
    pwm1 = 1'b0;
    hold(20);

    duty(12'h400);
    check("recover_silent", vld_cnt, 0);
    check("recover_cleared", stalled, 1'b0);
    duty(12'h400);
    check("recover_count", vld_cnt, 1);
    check("recover_spd", last_spd, 12'hC00);

    // Asynchronous reset between clock edges in the middle of a window.
    pwm1 = 1'b1;
    hold(1000);
    #3;
    rst = 1'b1;
    #1;
    check("async_rst_spd", spd, 12'h000);
    check("async_rst_vld", vld, 1'b0);
    check("async_rst_stalled", stalled, 1'b0);
    pwm1 = 1'b0;
    hold(5);
    rst = 1'b0;
    duty(12'hC00);
    check("post_rst_silent", vld_cnt, 0);
    duty(12'hC00);
    check("post_rst_count", vld_cnt, 1);
    check("post_rst_spd", last_spd, 12'h400);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
